// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side valid/ready bundle plus FIFO write port and arbiter status.
// The arbiter uses the slave modport; the block driving requesters and full uses master.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                fifo_full;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_wr_data;
    logic [GW-1:0]       grant_id;
    logic                busy;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for N_REQ producers onto one FIFO write port; 1-cycle grant, then 1 beat/cycle.
// Beats stall combinationally on fifo_full; a withdrawn valid or an exhausted burst returns to IDLE.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int            GW        = $clog2(N_REQ);
    localparam logic [3:0]    LAST_BEAT = 4'(MAX_BURST - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         r_state, w_state_nxt;
    logic [GW-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [GW-1:0]  r_grant_id, w_grant_id_nxt;
    logic [3:0]     r_beat_cnt, w_beat_cnt_nxt;
    logic [GW-1:0]  w_pick_idx, w_cand;
    logic           w_pick_vld;
    logic           w_gvld;
    logic           w_acc;

    assign w_gvld = bus.req_valid[r_grant_id];
    assign w_acc  = (r_state == S_GRANT) && !reset && w_gvld && !bus.fifo_full;

    // Scan from the far end back toward rr_ptr so the closest candidate wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = r_rr_ptr + GW'(k);
            if (bus.req_valid[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_id_nxt = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                if (!w_gvld) begin
                    w_state_nxt  = S_IDLE;
                    w_rr_ptr_nxt = r_grant_id + GW'(1);
                end else if (w_acc) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt  = S_IDLE;
                        w_rr_ptr_nxt = r_grant_id + GW'(1);
                    end
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_acc) bus.req_ready[r_grant_id] = 1'b1;
    end

    assign bus.fifo_wr_en   = w_acc;
    assign bus.fifo_wr_data = bus.req_data[r_grant_id*DW +: DW];
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = (r_state == S_GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector tables plus a write-data scoreboard.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       full;
        logic       e_busy;
        logic [1:0] e_gid;
        logic       e_wr;
        logic [3:0] e_rdy;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] sb_q[$];
    logic [7:0] base[N];
    logic [7:0] cnt[N];
    int         checks = 0;
    int         errors = 0;
    int         wr_count = 0;

    logic       s_busy;
    logic [1:0] s_gid;
    logic       s_wr;
    logic [3:0] s_rdy;

    function automatic vec_t v(input logic rst, input logic [3:0] vld, input logic full,
                               input logic eb, input logic [1:0] eg, input logic ew,
                               input logic [3:0] er);
        vec_t r;
        r.rst = rst; r.vld = vld; r.full = full;
        r.e_busy = eb; r.e_gid = eg; r.e_wr = ew; r.e_rdy = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Producers present base+beat_count; the count advances on each accepted beat.
    task automatic tick(input logic rst, input logic [3:0] vld, input logic full);
        reset         = rst;
        bus.req_valid = vld;
        bus.fifo_full = full;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = base[i] + cnt[i];
        @(negedge clk);
        s_busy = bus.busy;
        s_gid  = bus.grant_id;
        s_wr   = bus.fifo_wr_en;
        s_rdy  = bus.req_ready;
        if (bus.fifo_wr_en === 1'b1) begin
            wr_count++;
            chk("wr_while_full", 32'(bus.fifo_full), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write: got %0h expected no write", bus.fifo_wr_data);
            end else begin
                chk("sb_data", 32'(bus.fifo_wr_data), 32'(sb_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (s_rdy[i]) cnt[i] = cnt[i] + 8'd1;
    endtask

    task automatic run_table(input string nm);
        for (int k = 0; k < vt.size(); k++) begin
            tick(vt[k].rst, vt[k].vld, vt[k].full);
            chk($sformatf("%s[%0d].busy", nm, k), 32'(s_busy), 32'(vt[k].e_busy));
            chk($sformatf("%s[%0d].gid",  nm, k), 32'(s_gid),  32'(vt[k].e_gid));
            chk($sformatf("%s[%0d].wr",   nm, k), 32'(s_wr),   32'(vt[k].e_wr));
            chk($sformatf("%s[%0d].rdy",  nm, k), 32'(s_rdy),  32'(vt[k].e_rdy));
        end
        chk($sformatf("%s.sb_drained", nm), 32'(sb_q.size()), 32'd0);
        vt.delete();
    endtask

    task automatic new_scenario();
        for (int i = 0; i < N; i++) begin
            base[i] = 8'(i << 4);
            cnt[i]  = 8'd0;
        end
        wr_count = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        new_scenario();
        @(posedge clk);
        #1;

        // Reset held two cycles, then idle with no requests.
        vt.push_back(v(1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vt.push_back(v(1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        run_table("reset_idle");

        // Requester 2 alone with six beats: burst of 4, bubble, re-grant for the last 2.
        new_scenario();
        base[2] = 8'hA0;
        for (int b = 0; b < 6; b++) sb_q.push_back(8'(8'hA0 + b));
        vt.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000));
        for (int b = 0; b < 4; b++) vt.push_back(v(0, 4'b0100, 0, 1, 2, 1, 4'b0100));
        vt.push_back(v(0, 4'b0100, 0, 0, 2, 0, 4'b0000));
        for (int b = 0; b < 2; b++) vt.push_back(v(0, 4'b0100, 0, 1, 2, 1, 4'b0100));
        vt.push_back(v(0, 4'b0000, 0, 1, 2, 0, 4'b0000));
        vt.push_back(v(0, 4'b0000, 0, 0, 2, 0, 4'b0000));
        run_table("single_burst");

        // All four continuously valid after a reset: grants 0,1,2,3,0 with 4 beats each.
        new_scenario();
        tick(1, 4'b0000, 0);
        for (int g = 0; g < 5; g++) begin
            tick(0, 4'b1111, 0);
            chk($sformatf("rot%0d.bubble_busy", g), 32'(s_busy), 32'd0);
            chk($sformatf("rot%0d.bubble_gid", g), 32'(s_gid), (g == 0) ? 32'd0 : 32'((g - 1) % 4));
            for (int b = 0; b < 4; b++) begin
                sb_q.push_back(8'((((g % 4) << 4)) | ((g / 4) * 4 + b)));
                tick(0, 4'b1111, 0);
                chk($sformatf("rot%0d.%0d.gid", g, b), 32'(s_gid), 32'(g % 4));
                chk($sformatf("rot%0d.%0d.rdy", g, b), 32'(s_rdy), 32'(1 << (g % 4)));
            end
        end
        tick(0, 4'b0000, 0);
        chk("rot.writes", 32'(wr_count), 32'd20);
        chk("rot.sb_drained", 32'(sb_q.size()), 32'd0);

        // Requester 1 stalled three cycles by full during its second beat.
        new_scenario();
        for (int b = 0; b < 4; b++) sb_q.push_back(8'(8'h10 + b));
        vt.push_back(v(0, 4'b0010, 0, 0, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0010, 0, 1, 1, 1, 4'b0010));
        for (int s = 0; s < 3; s++) vt.push_back(v(0, 4'b0010, 1, 1, 1, 0, 4'b0000));
        for (int b = 0; b < 3; b++) vt.push_back(v(0, 4'b0010, 0, 1, 1, 1, 4'b0010));
        vt.push_back(v(0, 4'b0000, 0, 0, 1, 0, 4'b0000));
        run_table("full_stall");
        chk("full_stall.writes", 32'(wr_count), 32'd4);

        // Requester 3 withdraws after 2 beats; pointer wraps so 0 beats 1.
        new_scenario();
        sb_q.push_back(8'h30);
        sb_q.push_back(8'h31);
        sb_q.push_back(8'h00);
        vt.push_back(v(0, 4'b1000, 0, 0, 1, 0, 4'b0000));
        vt.push_back(v(0, 4'b1000, 0, 1, 3, 1, 4'b1000));
        vt.push_back(v(0, 4'b1000, 0, 1, 3, 1, 4'b1000));
        vt.push_back(v(0, 4'b0001, 0, 1, 3, 0, 4'b0000));
        vt.push_back(v(0, 4'b0011, 0, 0, 3, 0, 4'b0000));
        vt.push_back(v(0, 4'b0001, 0, 1, 0, 1, 4'b0001));
        vt.push_back(v(0, 4'b0000, 0, 1, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        run_table("release_wrap");

        // Reset during the third beat of requester 2; afterwards arbitration restarts at 0.
        new_scenario();
        base[2] = 8'hB0;
        sb_q.push_back(8'hB0);
        sb_q.push_back(8'hB1);
        sb_q.push_back(8'h00);
        vt.push_back(v(0, 4'b0100, 0, 0, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0100, 0, 1, 2, 1, 4'b0100));
        vt.push_back(v(0, 4'b0100, 0, 1, 2, 1, 4'b0100));
        vt.push_back(v(1, 4'b0100, 0, 1, 2, 0, 4'b0000));
        vt.push_back(v(0, 4'b0011, 0, 0, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0001, 0, 1, 0, 1, 4'b0001));
        vt.push_back(v(0, 4'b0000, 0, 1, 0, 0, 4'b0000));
        vt.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        run_table("reset_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that lets N_REQ producers share the single write port of the 16-entry, 8-bit synchronous FIFO. Each producer offers data over a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's wr_en/wr_data directly. It honours the FIFO full flag so that no write is ever issued into a full FIFO.

## Interface
- N_REQ, default 4: number of requesters; power of two, legal range 2..8.
- DW, default 8: data width; must match the FIFO data width.
- MAX_BURST, default 4: maximum beats per grant; legal range 1..16.
- GW, derived as clog2(N_REQ): width of grant_id.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  bit i set means requester i offers a beat.
- req_data  in  N_REQ*DW  requester i data occupies bits [i*DW +: DW].
- req_ready  out  N_REQ  bit i set means requester i's beat is accepted this cycle.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr_en  out  1  write strobe to the FIFO.
- fifo_wr_data  out  DW  write data to the FIFO.
- grant_id  out  GW  index of the current or last granted requester.
- busy  out  1  high while in GRANT.

## Operation
- Registered state:
  - state: IDLE or GRANT.
  - rr_ptr: GW bits, the highest-priority candidate.
  - grant_id.
  - beat_cnt: 4 bits.
- IDLE:
  - req_ready = 0 and fifo_wr_en = 0.
  - If any req_valid bit is set, choose the first set bit scanning rr_ptr, rr_ptr+1, … with modulo-N_REQ wrap.
  - Load grant_id with that index, clear beat_cnt, and go to GRANT.
  - If no bit is set, stay in IDLE.
- GRANT, with g = grant_id:
  - Beat accept is combinational: acc = req_valid[g] && !fifo_full.
  - req_ready[g] = acc; every other req_ready bit is 0.
  - fifo_wr_en = acc; fifo_wr_data = req_data[g].
  - When fifo_wr_en = 0, fifo_wr_data is don't-care; the implementation drives req_data[g].
  - On acc, beat_cnt is incremented.
- GRANT exits to IDLE, with rr_ptr <= (g+1) mod N_REQ, on either of:
  - acc with beat_cnt == MAX_BURST-1 (burst exhausted); or
  - req_valid[g] == 0 (requester withdrew).
- GRANT stays in GRANT on either of:
  - fifo_full = 1 with req_valid[g] = 1: stall, no beat, beat_cnt held, grant kept;
  - acc with beat_cnt < MAX_BURST-1.
- Fairness:
  - A requester loses priority only after being granted.
  - A continuously-valid requester waits at most (N_REQ-1) × (MAX_BURST+1) cycles for a grant, excluding full stalls.
- Requester obligations:
  - Data is sampled only on its accept cycle.
  - A requester may drop valid at any time; dropping releases its grant.
- busy = (state == GRANT).

## Timing
- Reset values (on the clock edge with reset high):
  - state = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0, busy = 0.
  - Consequently req_ready = 0 and fifo_wr_en = 0.
- While reset is high, req_ready and fifo_wr_en are forced to 0 regardless of state.
- Reset asserted mid-burst aborts the burst. No beat is accepted in the reset cycle, and arbitration restarts from requester 0.
- Arbitration latency: 1 cycle. A valid that rises in IDLE at edge k is granted at edge k+1; its first beat can be accepted in cycle k+1.
- Re-arbitration bubble: exactly 1 idle cycle between consecutive grants.
- Sustained throughput within a burst is 1 beat per cycle. A MAX_BURST burst therefore takes MAX_BURST+1 cycles including arbitration.
- fifo_full is sampled combinationally in the same cycle as the write. A write can never coincide with full = 1.
- Wrap-around: rr_ptr advances from N_REQ-1 to 0.
- A simultaneous full deassertion and valid drop in GRANT exits to IDLE with no beat.

## Test plan
- Reset then idle: hold reset 2 cycles and keep all req_valid = 0 -> busy = 0, req_ready = 0, fifo_wr_en = 0, grant_id = 0 throughout.
- Single requester burst: req_valid = 4'b0100, data 0xA0..0xA5 -> grant_id = 2 after 1 cycle; writes 0xA0..0xA3 on 4 consecutive cycles; 1 IDLE cycle; re-grant to 2; then 0xA4 and 0xA5 are written.
- Round-robin rotation: all four valid continuously, each requester sending its own index in the upper nibble -> grant order 0,1,2,3,0; exactly 4 writes per grant; FIFO receives 0x0_, 0x1_, 0x2_, 0x3_ groups in that order.
- Full stall: during requester 1's 2nd beat, force fifo_full = 1 for 3 cycles -> fifo_wr_en = 0 and req_ready = 0 for those 3 cycles; grant_id stays 1; the remaining 3 beats complete after full drops; total writes = 4.
- Early release and wrap: requester 3 drops valid after 2 beats while requester 0 is valid -> IDLE for 1 cycle; grant_id goes to 0; rr_ptr wraps 3 -> 0.
- Reset mid-burst: assert reset in the 3rd beat of a burst -> no write in that cycle; the next cycle shows busy = 0 and rr_ptr = 0.
